ysyx_24110006_lsu_fsm: RTL and testbench
========================================

# ysyx_24110006_lsu_fsm

Multi-cycle load/store unit for the ysyx_24110006 core, consuming the memory-access results of the EXU and producing load data for write-back. Accepts one request per handshake from the EXU and issues a single word-aligned access on a request/response memory port. It shifts store data and strobes, extracts and sign-/zero-extends load data, and detects misaligned accesses. It replaces the combinational LSU on the path from the EXU to the register-file write data once the core moves to handshaked stages.

## Interface
Parameters:
- none (data and address fixed at 32 bits).

Ports:
- i_clock  in  1  single clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  EXU request valid.
- o_ready  out  1  LSU can accept a request.
- i_ren  in  1  load request.
- i_wen  in  1  store request; takes priority if i_ren is also set.
- i_addr  in  32  byte address (EXU result).
- i_wdata  in  32  store data, right-aligned (rs2).
- i_wmask  in  4  store size mask: 0001 byte, 0011 half, 1111 word.
- i_read_t  in  3  load type (funct3): 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- o_valid  out  1  result valid to write-back.
- i_ready  in  1  write-back accepts result.
- o_rdata  out  32  extended load data; 0 for stores and no-op requests.
- o_err  out  1  misaligned access or illegal i_read_t; qualified by o_valid.
- o_mem_valid  out  1  memory request valid.
- i_mem_ready  in  1  memory accepts request.
- o_mem_wen  out  1  1 = write, 0 = read.
- o_mem_addr  out  32  {i_addr[31:2], 2'b00}.
- o_mem_wdata  out  32  i_wdata << (8*addr[1:0]).
- o_mem_wstrb  out  4  i_wmask << addr[1:0]; 0000 for reads.
- i_mem_rsp_valid  in  1  response (read data or write ack).
- i_mem_rsp_rdata  in  32  raw aligned read word.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset → IDLE.
- IDLE: o_ready=1. On i_valid: latch addr[1:0], read_t, wen, and the computed mem fields.
  - Misaligned (half at addr[0]=1, word at addr[1:0]≠0) or illegal read_t on a load → DONE with o_err=1, no memory access.
  - Neither ren nor wen → DONE, o_rdata=0, o_err=0.
  - Otherwise → REQ.
- REQ: o_mem_valid=1; mem outputs held stable. On i_mem_ready → WAIT.
- WAIT: on i_mem_rsp_valid → DONE; for loads, register o_rdata = extend(i_mem_rsp_rdata >> 8*addr[1:0]) per read_t; for stores, o_rdata=0.
- DONE: o_valid=1; o_rdata and o_err held. On i_ready → IDLE.
- i_mem_rsp_valid is ignored outside WAIT, and i_mem_ready outside REQ.
- Only one outstanding request; o_ready=0 in REQ, WAIT, and DONE.

## Timing
- Reset values: o_valid=0, o_mem_valid=0, o_rdata=0, o_err=0, o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0, o_mem_wstrb=0; o_ready=1 from the first cycle after reset.
- Accept at cycle N. o_mem_valid rises at N+1.
- With zero-wait memory (i_mem_ready at N+1, response at N+2), o_valid rises at N+3. Minimum latency from accept to o_valid is 3 cycles.
- An error or no-op request gives o_valid at N+1.
- The earliest response is the cycle after the request handshake. A same-cycle response is not supported.
- o_ready depends only on state, with no combinational path from i_valid.
- Back-to-back: i_ready in DONE at cycle M allows the next accept at M+1.
- Reset mid-operation: return to IDLE and drop the transaction. A late response arriving in IDLE is ignored.

## Test plan
- lw addr 0x8000_0004, memory returns 0xDEAD_BEEF with 2 wait cycles on ready and 3 on response → o_rdata 0xDEAD_BEEF, o_err=0, o_mem_wstrb=0000, o_mem_wen=0.
- lb addr 0x...03, word 0x80FF_1234 → o_rdata 0xFFFF_FF80. Same request as lbu → 0x0000_0080. lhu addr 0x...02 → 0x0000_80FF.
- sh addr 0x...02, wdata 0x1234_ABCD, wmask 0011 → o_mem_addr 0x...00, o_mem_wstrb 1100, o_mem_wdata 0xABCD_0000, o_mem_wen=1, o_rdata 0.
- lw addr 0x...01 → o_valid at N+1, o_err=1, o_mem_valid never asserted.
- i_ready held low 5 cycles in DONE → o_valid and o_rdata stable, o_ready=0. The next request is accepted the cycle after i_ready.
- Reset asserted in WAIT, then a response pulse in IDLE → all outputs at reset values, o_valid stays 0.

Source files
------------

// File: rtl/ysyx_24110006_lsu_fsm_if.sv
// EXU/write-back handshake and memory port of the ysyx_24110006 load/store unit.
// The slave modport belongs to the LSU; the master modport belongs to its environment.
interface ysyx_24110006_lsu_fsm_if;
    // EXU request side
    logic        i_valid;
    logic        o_ready;
    logic        i_ren;
    logic        i_wen;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wmask;
    logic [2:0]  i_read_t;

    // write-back result side
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rdata;
    logic        o_err;

    // memory request/response port
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic        o_mem_wen;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_rdata;

    modport slave (
        input  i_valid, i_ren, i_wen, i_addr, i_wdata, i_wmask, i_read_t,
        input  i_ready, i_mem_ready, i_mem_rsp_valid, i_mem_rsp_rdata,
        output o_ready, o_valid, o_rdata, o_err,
        output o_mem_valid, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wstrb
    );

    modport master (
        output i_valid, i_ren, i_wen, i_addr, i_wdata, i_wmask, i_read_t,
        output i_ready, i_mem_ready, i_mem_rsp_valid, i_mem_rsp_rdata,
        input  o_ready, o_valid, o_rdata, o_err,
        input  o_mem_valid, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wstrb
    );
endinterface

// File: rtl/ysyx_24110006_lsu_fsm.sv
// Multi-cycle LSU: one EXU request at a time, one word-aligned memory access,
// load extraction/extension and misalignment detection, result held until write-back takes it.
module ysyx_24110006_lsu_fsm (
    input  logic                          i_clock,
    input  logic                          i_reset,
    ysyx_24110006_lsu_fsm_if.slave        lsu
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q,     state_d;
    logic [1:0]  addr_lo_q,   addr_lo_d;
    logic [2:0]  read_t_q,    read_t_d;
    logic        wen_q,       wen_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        err_q,       err_d;

    logic        store_misaligned;
    logic        load_bad;
    logic        req_err;
    logic        req_noop;
    logic [31:0] rsp_shifted;
    logic [31:0] load_ext;

    // Request classification; a store wins over a load when both are raised.
    always_comb begin
        store_misaligned = 1'b0;
        case (lsu.i_wmask)
            4'b0011: store_misaligned = lsu.i_addr[0];
            4'b1111: store_misaligned = |lsu.i_addr[1:0];
            default: store_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        load_bad = 1'b0;
        case (lsu.i_read_t)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = lsu.i_addr[0];
            3'b010:         load_bad = |lsu.i_addr[1:0];
            default:        load_bad = 1'b1;
        endcase
    end

    assign req_err  = lsu.i_wen ? store_misaligned : (lsu.i_ren & load_bad);
    assign req_noop = ~lsu.i_wen & ~lsu.i_ren;

    assign rsp_shifted = lsu.i_mem_rsp_rdata >> {addr_lo_q, 3'b000};

    always_comb begin
        load_ext = 32'd0;
        case (read_t_q)
            3'b000:  load_ext = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
            3'b001:  load_ext = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b010:  load_ext = rsp_shifted;
            3'b100:  load_ext = {24'd0, rsp_shifted[7:0]};
            3'b101:  load_ext = {16'd0, rsp_shifted[15:0]};
            default: load_ext = 32'd0;
        endcase
    end

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through the case infers a latch.
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        read_t_d    = read_t_q;
        wen_d       = wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (lsu.i_valid) begin
                    addr_lo_d   = lsu.i_addr[1:0];
                    read_t_d    = lsu.i_read_t;
                    wen_d       = lsu.i_wen;
                    mem_addr_d  = {lsu.i_addr[31:2], 2'b00};
                    mem_wdata_d = lsu.i_wdata << {lsu.i_addr[1:0], 3'b000};
                    mem_wstrb_d = lsu.i_wen ? (lsu.i_wmask << lsu.i_addr[1:0]) : 4'b0000;
                    rdata_d     = 32'd0;
                    err_d       = req_err;
                    if (req_err || req_noop) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (lsu.i_mem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lsu.i_mem_rsp_valid) begin
                    rdata_d = wen_q ? 32'd0 : load_ext;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (lsu.i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        // NOTE: reset is synchronous; every register, datapath included, returns to zero so
        // the memory port and result outputs show clean values straight out of reset.
        if (i_reset) begin
            state_q     <= S_IDLE;
            addr_lo_q   <= 2'd0;
            read_t_q    <= 3'd0;
            wen_q       <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            read_t_q    <= read_t_d;
            wen_q       <= wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Handshake outputs are pure state decodes: no combinational path from i_valid.
    assign lsu.o_ready     = (state_q == S_IDLE);
    assign lsu.o_valid     = (state_q == S_DONE);
    assign lsu.o_mem_valid = (state_q == S_REQ);
    assign lsu.o_mem_wen   = wen_q;
    assign lsu.o_mem_addr  = mem_addr_q;
    assign lsu.o_mem_wdata = mem_wdata_q;
    assign lsu.o_mem_wstrb = mem_wstrb_q;
    assign lsu.o_rdata     = rdata_q;
    assign lsu.o_err       = err_q;

endmodule

// File: tb/tb_ysyx_24110006_lsu_fsm.sv
// Self-checking bench for ysyx_24110006_lsu_fsm: vector table driven through a task,
// expected write-back results queued at accept and popped at the write-back handshake.
module tb_ysyx_24110006_lsu_fsm;

    typedef struct {
        string       name;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [2:0]  read_t;
        logic [31:0] rsp;
        bit          use_mem;
        logic        mem_wen;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
        logic [31:0] rdata;
        logic        err;
        int          rdy_wait;
        int          rsp_wait;
        int          done_wait;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam int NVEC = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs [NVEC];
    exp_t sb_q [$];

    ysyx_24110006_lsu_fsm_if bus ();

    ysyx_24110006_lsu_fsm dut (
        .i_clock (clk),
        .i_reset (rst),
        .lsu     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " o_valid"},     32'(bus.o_valid),     32'd0);
        check({tag, " o_mem_valid"}, 32'(bus.o_mem_valid), 32'd0);
        check({tag, " o_rdata"},     bus.o_rdata,          32'd0);
        check({tag, " o_err"},       32'(bus.o_err),       32'd0);
        check({tag, " o_mem_wen"},   32'(bus.o_mem_wen),   32'd0);
        check({tag, " o_mem_addr"},  bus.o_mem_addr,       32'd0);
        check({tag, " o_mem_wdata"}, bus.o_mem_wdata,      32'd0);
        check({tag, " o_mem_wstrb"}, 32'(bus.o_mem_wstrb), 32'd0);
    endtask

    // Called at a negedge with the DUT expected idle; returns at the negedge after write-back.
    task automatic run_txn(input vec_t v);
        exp_t e;
        int   k;
        check({v.name, " o_ready at accept"}, 32'(bus.o_ready), 32'd1);
        bus.i_valid  = 1'b1;
        bus.i_ren    = v.ren;
        bus.i_wen    = v.wen;
        bus.i_addr   = v.addr;
        bus.i_wdata  = v.wdata;
        bus.i_wmask  = v.wmask;
        bus.i_read_t = v.read_t;
        e.rdata = v.rdata;
        e.err   = v.err;
        sb_q.push_back(e);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_addr  = $urandom;
        bus.i_wdata = $urandom;

        if (v.use_mem) begin
            check({v.name, " o_mem_valid at N+1"}, 32'(bus.o_mem_valid), 32'd1);
            check({v.name, " o_ready in REQ"},     32'(bus.o_ready),     32'd0);
            check({v.name, " o_mem_wen"},          32'(bus.o_mem_wen),   32'(v.mem_wen));
            check({v.name, " o_mem_addr"},         bus.o_mem_addr,       v.mem_addr);
            check({v.name, " o_mem_wdata"},        bus.o_mem_wdata,      v.mem_wdata);
            check({v.name, " o_mem_wstrb"},        32'(bus.o_mem_wstrb), 32'(v.mem_wstrb));
            for (k = 0; k < v.rdy_wait; k++) begin
                bus.i_mem_rsp_valid = 1'b1;
                bus.i_mem_rsp_rdata = $urandom;
                @(negedge clk);
                check({v.name, " o_mem_valid held"}, 32'(bus.o_mem_valid), 32'd1);
                check({v.name, " o_mem_addr held"},  bus.o_mem_addr,       v.mem_addr);
                check({v.name, " o_mem_wdata held"}, bus.o_mem_wdata,      v.mem_wdata);
            end
            bus.i_mem_rsp_valid = 1'b0;
            bus.i_mem_ready = 1'b1;
            @(negedge clk);
            bus.i_mem_ready = 1'b0;
            check({v.name, " o_mem_valid drops in WAIT"}, 32'(bus.o_mem_valid), 32'd0);
            for (k = 0; k < v.rsp_wait; k++) begin
                check({v.name, " o_valid low in WAIT"}, 32'(bus.o_valid), 32'd0);
                @(negedge clk);
            end
            bus.i_mem_rsp_valid = 1'b1;
            bus.i_mem_rsp_rdata = v.rsp;
            @(negedge clk);
            bus.i_mem_rsp_valid = 1'b0;
            bus.i_mem_rsp_rdata = $urandom;
        end else begin
            check({v.name, " no memory request"}, 32'(bus.o_mem_valid), 32'd0);
        end

        check({v.name, " o_valid latency"}, 32'(bus.o_valid), 32'd1);
        for (k = 0; k < 20 && !bus.o_valid; k++) @(negedge clk);
        if (!bus.o_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s o_valid timeout: got 0, expected 1 within 20 cycles", v.name);
        end

        for (k = 0; k < v.done_wait; k++) begin
            check({v.name, " o_valid held"}, 32'(bus.o_valid), 32'd1);
            check({v.name, " o_ready in DONE"}, 32'(bus.o_ready), 32'd0);
            check({v.name, " o_rdata held"}, bus.o_rdata, v.rdata);
            @(negedge clk);
        end

        bus.i_ready = 1'b1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, expected one entry", v.name);
        end else begin
            e = sb_q.pop_front();
            check({v.name, " o_rdata"}, bus.o_rdata,     e.rdata);
            check({v.name, " o_err"},   32'(bus.o_err),  32'(e.err));
        end
        @(negedge clk);
        bus.i_ready = 1'b0;
        check({v.name, " o_valid after write-back"}, 32'(bus.o_valid), 32'd0);
        check({v.name, " o_ready after write-back"}, 32'(bus.o_ready), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //          name            ren   wen   addr          wdata         wmask    rt      rsp           mem wen   mem_addr      mem_wdata     wstrb    rdata         err  rw rs dw
        vecs[0]  = '{"lw_aligned",  1'b1, 1'b0, 32'h8000_0004, 32'h0,        4'b0000, 3'b010, 32'hDEAD_BEEF, 1, 1'b0, 32'h8000_0004, 32'h0,        4'b0000, 32'hDEAD_BEEF, 1'b0, 2, 3, 0};
        vecs[1]  = '{"lb_off3",     1'b1, 1'b0, 32'h8000_0003, 32'h0,        4'b0000, 3'b000, 32'h80FF_1234, 1, 1'b0, 32'h8000_0000, 32'h0,        4'b0000, 32'hFFFF_FF80, 1'b0, 0, 0, 0};
        vecs[2]  = '{"lbu_off3",    1'b1, 1'b0, 32'h8000_0003, 32'h0,        4'b0000, 3'b100, 32'h80FF_1234, 1, 1'b0, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_0080, 1'b0, 1, 0, 0};
        vecs[3]  = '{"lhu_off2",    1'b1, 1'b0, 32'h8000_0002, 32'h0,        4'b0000, 3'b101, 32'h80FF_1234, 1, 1'b0, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_80FF, 1'b0, 0, 1, 0};
        vecs[4]  = '{"lh_off2",     1'b1, 1'b0, 32'h8000_0002, 32'h0,        4'b0000, 3'b001, 32'h80FF_1234, 1, 1'b0, 32'h8000_0000, 32'h0,        4'b0000, 32'hFFFF_80FF, 1'b0, 0, 0, 5};
        vecs[5]  = '{"sh_off2",     1'b0, 1'b1, 32'h8000_0002, 32'h1234_ABCD, 4'b0011, 3'b000, 32'hFFFF_FFFF, 1, 1'b1, 32'h8000_0000, 32'hABCD_0000, 4'b1100, 32'h0,        1'b0, 1, 2, 0};
        vecs[6]  = '{"sb_off1",     1'b0, 1'b1, 32'h8000_0001, 32'h0000_00A5, 4'b0001, 3'b000, 32'h1111_1111, 1, 1'b1, 32'h8000_0000, 32'h0000_A500, 4'b0010, 32'h0,        1'b0, 0, 0, 0};
        vecs[7]  = '{"sw_aligned",  1'b0, 1'b1, 32'h8000_0008, 32'h1122_3344, 4'b1111, 3'b010, 32'h5555_5555, 1, 1'b1, 32'h8000_0008, 32'h1122_3344, 4'b1111, 32'h0,        1'b0, 0, 0, 1};
        vecs[8]  = '{"lw_misalign", 1'b1, 1'b0, 32'h8000_0001, 32'h0,        4'b0000, 3'b010, 32'h0,        0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 0, 0, 0};
        vecs[9]  = '{"lh_misalign", 1'b1, 1'b0, 32'h8000_0003, 32'h0,        4'b0000, 3'b001, 32'h0,        0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 0, 0, 2};
        vecs[10] = '{"illegal_rt",  1'b1, 1'b0, 32'h8000_0000, 32'h0,        4'b0000, 3'b011, 32'h0,        0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 0, 0, 0};
        vecs[11] = '{"sw_misalign", 1'b0, 1'b1, 32'h8000_0002, 32'hCAFE_F00D, 4'b1111, 3'b000, 32'h0,        0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 0, 0, 0};
        vecs[12] = '{"noop",        1'b0, 1'b0, 32'h8000_0010, 32'h0,        4'b0000, 3'b010, 32'h0,        0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 0, 0, 0};
        vecs[13] = '{"st_over_ld",  1'b1, 1'b1, 32'h8000_0000, 32'h1234_56FF, 4'b0001, 3'b011, 32'hAAAA_AAAA, 1, 1'b1, 32'h8000_0000, 32'h1234_56FF, 4'b0001, 32'h0,        1'b0, 0, 0, 0};
        vecs[14] = '{"lhu_off0",    1'b1, 1'b0, 32'h8000_0000, 32'h0,        4'b0000, 3'b101, 32'hFFFF_8001, 1, 1'b0, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_8001, 1'b0, 0, 0, 0};
        vecs[15] = '{"lb_off1_pos", 1'b1, 1'b0, 32'h8000_0001, 32'h0,        4'b0000, 3'b000, 32'h0000_7F00, 1, 1'b0, 32'h8000_0000, 32'h0,        4'b0000, 32'h0000_007F, 1'b0, 0, 0, 0};

        rst                 = 1'b1;
        bus.i_valid         = 1'b0;
        bus.i_ren           = 1'b0;
        bus.i_wen           = 1'b0;
        bus.i_addr          = 32'd0;
        bus.i_wdata         = 32'd0;
        bus.i_wmask         = 4'd0;
        bus.i_read_t        = 3'd0;
        bus.i_ready         = 1'b0;
        bus.i_mem_ready     = 1'b0;
        bus.i_mem_rsp_valid = 1'b0;
        bus.i_mem_rsp_rdata = 32'd0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("o_ready after reset", 32'(bus.o_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) run_txn(vecs[i]);

        // Reset while a load waits for its response, then a stale response arrives in IDLE.
        bus.i_valid  = 1'b1;
        bus.i_ren    = 1'b1;
        bus.i_wen    = 1'b0;
        bus.i_addr   = 32'h8000_0004;
        bus.i_read_t = 3'b010;
        sb_q.push_back('{32'h1357_9BDF, 1'b0});
        @(negedge clk);
        bus.i_valid     = 1'b0;
        bus.i_mem_ready = 1'b1;
        @(negedge clk);
        bus.i_mem_ready = 1'b0;
        check("midrst o_mem_valid in WAIT", 32'(bus.o_mem_valid), 32'd0);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        check("midrst o_ready", 32'(bus.o_ready), 32'd1);
        bus.i_mem_rsp_valid = 1'b1;
        bus.i_mem_rsp_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus.i_mem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_reset_outputs("late rsp");
            check("late rsp o_ready", 32'(bus.o_ready), 32'd1);
            @(negedge clk);
        end

        // The unit must recover cleanly after the dropped transaction.
        run_txn(vecs[1]);
        run_txn(vecs[5]);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
